// File: rtl/i2s_format_cfg.sv
// i2s_format_cfg: decodes and validates register-domain I2S/TDM format codes and
// switches the active format atomically on a frame boundary.
// Optional feature: define I2S_CFG_TIMEOUT_EN to force the apply after
// TIMEOUT_CYCLES cycles in PENDING without a frame_start (stopped BCLK).
module i2s_format_cfg #(
  parameter int unsigned MAX_CH         = 16,
  parameter int unsigned SLOT_WIDTH     = 32,
  parameter int unsigned DEF_WORD_WIDTH = 32,
  parameter int unsigned DEF_CH         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] cfg_valid_word_width_i,
  input  logic [2:0] cfg_tdm_num_i,
  input  logic       cfg_update_i,
  input  logic       frame_start_i,
  output logic [5:0] valid_word_width_real_o,
  output logic [4:0] channel_num_o,
  output logic [9:0] bits_per_frame_o,
  output logic       cfg_busy_o,
  output logic       cfg_applied_o,
  output logic       cfg_err_o,
  output logic       cfg_active_o
`ifdef I2S_CFG_TIMEOUT_EN
  ,
  output logic       cfg_timeout_o
`endif
);

  localparam int unsigned SLOT_SHIFT = $clog2(SLOT_WIDTH);
  localparam logic [9:0]  DEF_BPF    = 10'(DEF_CH << SLOT_SHIFT);

  // Reject parameter sets the frame engines cannot handle.
  if ((SLOT_WIDTH == 0) || ((SLOT_WIDTH & (SLOT_WIDTH - 1)) != 0)) begin : g_bad_slot
    $error("SLOT_WIDTH must be a power of two");
  end
  if ((MAX_CH < 2) || (MAX_CH > 16) || ((MAX_CH & (MAX_CH - 1)) != 0)) begin : g_bad_max_ch
    $error("MAX_CH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ww_code_q, ww_code_d;
  logic [2:0] tdm_code_q, tdm_code_d;
  logic [5:0] sh_ww_q, sh_ww_d;
  logic [4:0] sh_ch_q, sh_ch_d;
  logic [5:0] ww_q, ww_d;
  logic [4:0] ch_q, ch_d;
  logic [9:0] bpf_q, bpf_d;
  logic       busy_q, busy_d;
  logic       applied_q, applied_d;
  logic       err_q, err_d;
  logic       active_q, active_d;
  logic [5:0] dec_ww;
  logic [4:0] dec_ch;
  logic       dec_illegal;
  logic       timeout_hit;
  logic       apply;

`ifdef I2S_CFG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign timeout_hit = (state_q == ST_PENDING) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // PENDING dwell counter; it is zero whenever the FSM is outside PENDING.
  always_comb begin
    cnt_d     = '0;
    timeout_d = apply && !frame_start_i;
    if (state_q == ST_PENDING && state_d == ST_PENDING) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Timeout counter and pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign cfg_timeout_o = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // Decode the latched shadow codes into real values and check build limits.
  always_comb begin
    dec_ww = 6'd0;
    dec_ch = 5'd0;
    case (ww_code_q)
      2'd1:    dec_ww = 6'd16;
      2'd2:    dec_ww = 6'd24;
      2'd3:    dec_ww = 6'd32;
      default: dec_ww = 6'd0;
    endcase
    case (tdm_code_q)
      3'd0:    dec_ch = 5'd2;
      3'd1:    dec_ch = 5'd4;
      3'd2:    dec_ch = 5'd8;
      3'd3:    dec_ch = 5'd16;
      default: dec_ch = 5'd0;
    endcase
    dec_illegal = (ww_code_q == 2'd0) || (tdm_code_q > 3'd3) ||
                  (32'(dec_ch) > MAX_CH) || (32'(dec_ww) > SLOT_WIDTH);
  end

  // Next-state and output logic; a new update always restarts at DECODE.
  always_comb begin
    state_d    = state_q;
    ww_code_d  = ww_code_q;
    tdm_code_d = tdm_code_q;
    sh_ww_d    = sh_ww_q;
    sh_ch_d    = sh_ch_q;
    ww_d       = ww_q;
    ch_d       = ch_q;
    bpf_d      = bpf_q;
    applied_d  = 1'b0;
    err_d      = 1'b0;
    active_d   = active_q;
    apply      = 1'b0;

    if (cfg_update_i) begin
      ww_code_d  = cfg_valid_word_width_i;
      tdm_code_d = cfg_tdm_num_i;
      state_d    = ST_DECODE;
    end else begin
      case (state_q)
        ST_DECODE: begin
          if (dec_illegal) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sh_ww_d = dec_ww;
            sh_ch_d = dec_ch;
            state_d = ST_PENDING;
          end
        end
        ST_PENDING: begin
          apply = frame_start_i || timeout_hit;
        end
        default: state_d = state_q;
      endcase
    end

    if (apply) begin
      ww_d      = sh_ww_q;
      ch_d      = sh_ch_q;
      bpf_d     = 10'(sh_ch_q) << SLOT_SHIFT;
      applied_d = 1'b1;
      active_d  = 1'b1;
      state_d   = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, shadow and active-format registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ww_code_q  <= 2'd0;
      tdm_code_q <= 3'd0;
      sh_ww_q    <= 6'd0;
      sh_ch_q    <= 5'd0;
      ww_q       <= 6'(DEF_WORD_WIDTH);
      ch_q       <= 5'(DEF_CH);
      bpf_q      <= DEF_BPF;
      busy_q     <= 1'b0;
      applied_q  <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ww_code_q  <= ww_code_d;
      tdm_code_q <= tdm_code_d;
      sh_ww_q    <= sh_ww_d;
      sh_ch_q    <= sh_ch_d;
      ww_q       <= ww_d;
      ch_q       <= ch_d;
      bpf_q      <= bpf_d;
      busy_q     <= busy_d;
      applied_q  <= applied_d;
      err_q      <= err_d;
      active_q   <= active_d;
    end
  end

  assign valid_word_width_real_o = ww_q;
  assign channel_num_o           = ch_q;
  assign bits_per_frame_o        = bpf_q;
  assign cfg_busy_o              = busy_q;
  assign cfg_applied_o           = applied_q;
  assign cfg_err_o               = err_q;
  assign cfg_active_o            = active_q;

endmodule

// File: tb/tb_i2s_format_cfg.sv
// Bench for i2s_format_cfg: two instances (MAX_CH=16 and MAX_CH=8) share one
// directed stimulus stream and are checked every cycle against a request/age model.
module tb_i2s_format_cfg;

  localparam int unsigned SLOT = 32;
  localparam int unsigned TMO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ww_code = 2'd0;
  logic [2:0] tdm_code = 3'd0;
  logic       upd = 1'b0;
  logic       fs = 1'b0;

  logic [5:0] ww_o   [2];
  logic [4:0] ch_o   [2];
  logic [9:0] bpf_o  [2];
  logic       busy_o [2];
  logic       app_o  [2];
  logic       err_o  [2];
  logic       act_o  [2];
`ifdef I2S_CFG_TIMEOUT_EN
  logic       tmo_o  [2];
`endif

  int total = 0;
  int bad = 0;
  int app_cnt [2] = '{0, 0};
  int tmo_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  i2s_format_cfg #(.MAX_CH(16), .SLOT_WIDTH(SLOT), .DEF_WORD_WIDTH(32), .DEF_CH(2),
                   .TIMEOUT_CYCLES(TMO)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_word_width_i(ww_code), .cfg_tdm_num_i(tdm_code),
    .cfg_update_i(upd), .frame_start_i(fs),
    .valid_word_width_real_o(ww_o[0]), .channel_num_o(ch_o[0]), .bits_per_frame_o(bpf_o[0]),
    .cfg_busy_o(busy_o[0]), .cfg_applied_o(app_o[0]), .cfg_err_o(err_o[0]),
    .cfg_active_o(act_o[0])
`ifdef I2S_CFG_TIMEOUT_EN
    , .cfg_timeout_o(tmo_o[0])
`endif
  );

  i2s_format_cfg #(.MAX_CH(8), .SLOT_WIDTH(SLOT), .DEF_WORD_WIDTH(32), .DEF_CH(2),
                   .TIMEOUT_CYCLES(TMO)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .cfg_valid_word_width_i(ww_code), .cfg_tdm_num_i(tdm_code),
    .cfg_update_i(upd), .frame_start_i(fs),
    .valid_word_width_real_o(ww_o[1]), .channel_num_o(ch_o[1]), .bits_per_frame_o(bpf_o[1]),
    .cfg_busy_o(busy_o[1]), .cfg_applied_o(app_o[1]), .cfg_err_o(err_o[1]),
    .cfg_active_o(act_o[1])
`ifdef I2S_CFG_TIMEOUT_EN
    , .cfg_timeout_o(tmo_o[1])
`endif
  );

  // ---------------- behavioural model ----------------
  // A request is remembered with the cycle it arrived; one cycle later it is
  // judged legal or not, from two cycles on it waits for a frame start.
  int cyc;
  int m_ww [2], m_ch [2], m_act [2], m_busy [2], m_app [2], m_err [2], m_tmo [2];
  int req [2], req_wc [2], req_tc [2], req_cyc [2];

  function automatic int word_of(int wc);
    return 8 * wc + 8;
  endfunction

  function automatic int chans_of(int tc);
    return 1 << (tc + 1);
  endfunction

  function automatic int cfg_illegal(int wc, int tc, int maxc);
    if (wc == 0 || tc > 3) return 1;
    if (chans_of(tc) > maxc || word_of(wc) > int'(SLOT)) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int age;
    int maxc;
    int tmo_hit;
    if (rst) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_ww[i] = 32; m_ch[i] = 2; m_act[i] = 0; m_busy[i] = 0;
        m_app[i] = 0; m_err[i] = 0; m_tmo[i] = 0; req[i] = 0;
        req_wc[i] = 0; req_tc[i] = 0; req_cyc[i] = 0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        maxc = (i == 0) ? 16 : 8;
        m_app[i] = 0; m_err[i] = 0; m_tmo[i] = 0;
        age = cyc - req_cyc[i];
        tmo_hit = 0;
`ifdef I2S_CFG_TIMEOUT_EN
        tmo_hit = (age - 2 == int'(TMO) - 1) ? 1 : 0;
`endif
        if (upd) begin
          req[i] = 1; req_wc[i] = int'(ww_code); req_tc[i] = int'(tdm_code); req_cyc[i] = cyc;
        end else if (req[i] != 0 && age == 1) begin
          if (cfg_illegal(req_wc[i], req_tc[i], maxc) != 0) begin
            m_err[i] = 1;
            req[i] = 0;
          end
        end else if (req[i] != 0 && age >= 2) begin
          if (fs || tmo_hit != 0) begin
            m_ww[i] = word_of(req_wc[i]);
            m_ch[i] = chans_of(req_tc[i]);
            m_app[i] = 1;
            m_act[i] = 1;
            m_tmo[i] = fs ? 0 : 1;
            req[i] = 0;
          end
        end
        m_busy[i] = req[i];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ww%0d", i),      int'(ww_o[i]),   m_ww[i]);
      chk($sformatf("ch%0d", i),      int'(ch_o[i]),   m_ch[i]);
      chk($sformatf("bpf%0d", i),     int'(bpf_o[i]),  m_ch[i] * int'(SLOT));
      chk($sformatf("busy%0d", i),    int'(busy_o[i]), m_busy[i]);
      chk($sformatf("applied%0d", i), int'(app_o[i]),  m_app[i]);
      chk($sformatf("err%0d", i),     int'(err_o[i]),  m_err[i]);
      chk($sformatf("active%0d", i),  int'(act_o[i]),  m_act[i]);
      chk($sformatf("excl%0d", i),    int'(app_o[i] & err_o[i]), 0);
      if (app_o[i]) app_cnt[i]++;
`ifdef I2S_CFG_TIMEOUT_EN
      chk($sformatf("timeout%0d", i), int'(tmo_o[i]),  m_tmo[i]);
      if (tmo_o[i]) tmo_cnt[i]++;
`endif
    end
  endtask

  // Advance n cycles, comparing at each falling edge; returns 2 units after a rising edge.
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      cmp_all();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic upd_cfg(logic [1:0] w, logic [2:0] t);
    ww_code = w; tdm_code = t; upd = 1'b1;
    tick(1);
    upd = 1'b0;
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    tick(1);
    fs = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int c0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_ww",  int'(ww_o[0]),  32);
    chk("rst_ch",  int'(ch_o[0]),  2);
    chk("rst_bpf", int'(bpf_o[0]), 64);
    chk("rst_act", int'(act_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    tick(2);

    // Apply after reset: ww=2 (24), tdm=2 (8 ch), frame_start 5 cycles later.
    upd_cfg(2'd2, 3'd2);
    tick(4);
    chk("t1_hold_ww",  int'(ww_o[0]),  32);
    chk("t1_hold_bpf", int'(bpf_o[0]), 64);
    chk("t1_busy",     int'(busy_o[0]), 1);
    pulse_fs();
    chk("t1_applied", int'(app_o[0]), 1);
    chk("t1_ww",      int'(ww_o[0]),  24);
    chk("t1_ch",      int'(ch_o[0]),  8);
    chk("t1_bpf",     int'(bpf_o[0]), 256);
    chk("t1_active",  int'(act_o[0]), 1);
    chk("t1_bpf_max8", int'(bpf_o[1]), 256);
    tick(2);

    // Illegal word code.
    upd_cfg(2'd0, 3'd1);
    tick(1);
    chk("t2_err0", int'(err_o[0]), 1);
    chk("t2_err1", int'(err_o[1]), 1);
    tick(1);
    chk("t2_busy", int'(busy_o[0]), 0);
    pulse_fs();
    chk("t2_app", int'(app_o[0]), 0);
    chk("t2_ww",  int'(ww_o[0]),  24);
    chk("t2_bpf", int'(bpf_o[0]), 256);

    // 16 channels: legal on MAX_CH=16, rejected on MAX_CH=8; then tdm code 4.
    upd_cfg(2'd3, 3'd3);
    tick(1);
    chk("t3_err_max8",  int'(err_o[1]), 1);
    chk("t3_err_max16", int'(err_o[0]), 0);
    tick(1);
    pulse_fs();
    chk("t3_ch16",    int'(ch_o[0]),  16);
    chk("t3_bpf512",  int'(bpf_o[0]), 512);
    chk("t3_bpf_max8", int'(bpf_o[1]), 256);
    tick(2);
    upd_cfg(2'd1, 3'd4);
    tick(1);
    chk("t3_err_tdm4", int'(err_o[0]), 1);
    tick(2);

    // Overwrite in PENDING.
    c0 = app_cnt[0];
    upd_cfg(2'd1, 3'd0);
    tick(3);
    upd_cfg(2'd3, 3'd1);
    tick(3);
    pulse_fs();
    chk("t4_ww",  int'(ww_o[0]),  32);
    chk("t4_ch",  int'(ch_o[0]),  4);
    chk("t4_bpf", int'(bpf_o[0]), 128);
    tick(3);
    chk("t4_one_apply", app_cnt[0] - c0, 1);

    // Update and frame_start together in PENDING: update wins.
    upd_cfg(2'd1, 3'd1);
    tick(3);
    ww_code = 2'd2; tdm_code = 3'd0; upd = 1'b1; fs = 1'b1;
    tick(1);
    upd = 1'b0; fs = 1'b0;
    chk("t5_no_app", int'(app_o[0]), 0);
    tick(3);
    chk("t5_hold_bpf", int'(bpf_o[0]), 128);
    chk("t5_busy",     int'(busy_o[0]), 1);
    pulse_fs();
    chk("t5_ww",  int'(ww_o[0]),  24);
    chk("t5_bpf", int'(bpf_o[0]), 64);
    tick(2);

    // Update during DECODE restarts with the newer codes.
    upd_cfg(2'd1, 3'd0);
    upd_cfg(2'd2, 3'd1);
    tick(2);
    pulse_fs();
    chk("t6_ww",  int'(ww_o[0]),  24);
    chk("t6_bpf", int'(bpf_o[0]), 128);
    tick(2);

    // No frame_start for a long time.
    c0 = tmo_cnt[0];
    upd_cfg(2'd1, 3'd2);
    tick(24);
`ifdef I2S_CFG_TIMEOUT_EN
    chk("t7_tmo_ww",   int'(ww_o[0]),  16);
    chk("t7_tmo_bpf",  int'(bpf_o[0]), 256);
    chk("t7_tmo_busy", int'(busy_o[0]), 0);
    chk("t7_tmo_cnt",  tmo_cnt[0] - c0, 1);
`else
    chk("t7_wait_ww",   int'(ww_o[0]),  24);
    chk("t7_wait_busy", int'(busy_o[0]), 1);
    chk("t7_wait_tmo",  tmo_cnt[0] - c0, 0);
    pulse_fs();
    chk("t7_ww",  int'(ww_o[0]),  16);
    chk("t7_bpf", int'(bpf_o[0]), 256);
`endif
    tick(2);

    // Reset mid-PENDING, asserted between clock edges.
    upd_cfg(2'd3, 3'd0);
    tick(3);
    #1 rst = 1'b1;
    #1;
    chk("t8_ww",     int'(ww_o[0]),  32);
    chk("t8_ch",     int'(ch_o[0]),  2);
    chk("t8_bpf",    int'(bpf_o[0]), 64);
    chk("t8_active", int'(act_o[0]), 0);
    chk("t8_busy",   int'(busy_o[0]), 0);
    tick(2);
    rst = 1'b0;
    c0 = app_cnt[0];
    tick(1);
    pulse_fs();
    tick(3);
    chk("t8_after_ww",  int'(ww_o[0]), 32);
    chk("t8_after_act", int'(act_o[0]), 0);
    chk("t8_no_apply",  app_cnt[0] - c0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
